// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one step per clock.
// Optional feature macro DIVIDER_DBZ_FLAG_EN adds a div_by_zero flag and a one-cycle divide-by-zero path.
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(2*WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DBZ  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_count, w_count_nxt;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [2*WIDTH-1:0] r_work, w_work_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [2*WIDTH-1:0] r_quotient, w_quotient_nxt;
  logic [WIDTH-1:0]   r_remainder, w_remainder_nxt;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic               r_dbz, w_dbz_nxt;
`endif

  // After a restore the partial remainder is below the divisor, so WIDTH bits
  // hold it; the extra bit only lives in the shifted trial value.
  logic [WIDTH:0]     w_shifted;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_step;

  assign w_shifted  = {r_rem, r_work[2*WIDTH-1]};
  assign w_ge       = (w_shifted >= {1'b0, r_divisor});
  assign w_rem_step = w_ge ? WIDTH'(w_shifted - {1'b0, r_divisor}) : w_shifted[WIDTH-1:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_work_nxt      = r_work;
    w_divisor_nxt   = r_divisor;
    w_rem_nxt       = r_rem;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
    w_dbz_nxt       = r_dbz;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_work_nxt    = dividend;
          w_divisor_nxt = divisor;
          w_count_nxt   = {CW{1'b0}};
          w_rem_nxt     = {WIDTH{1'b0}};
          w_busy_nxt    = 1'b1;
`ifdef DIVIDER_DBZ_FLAG_EN
          w_dbz_nxt     = 1'b0;
          if (divisor == {WIDTH{1'b0}}) begin
            w_state_nxt = S_DBZ;
          end else begin
            w_state_nxt = S_RUN;
          end
`else
          w_state_nxt   = S_RUN;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_work_nxt  = {r_work[2*WIDTH-2:0], w_ge};
        w_rem_nxt   = w_rem_step;
        w_count_nxt = r_count + CW'(1);
        if (r_count == LAST_STEP) begin
          w_state_nxt     = S_IDLE;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
          w_quotient_nxt  = {r_work[2*WIDTH-2:0], w_ge};
          w_remainder_nxt = w_rem_step;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
`ifdef DIVIDER_DBZ_FLAG_EN
      S_DBZ: begin
        w_state_nxt     = S_IDLE;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b1;
        w_dbz_nxt       = 1'b1;
        w_quotient_nxt  = {(2*WIDTH){1'b1}};
        w_remainder_nxt = r_work[WIDTH-1:0];
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= {CW{1'b0}};
      r_work      <= {(2*WIDTH){1'b0}};
      r_divisor   <= {WIDTH{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= {(2*WIDTH){1'b0}};
      r_remainder <= {WIDTH{1'b0}};
`ifdef DIVIDER_DBZ_FLAG_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_work      <= w_work_nxt;
      r_divisor   <= w_divisor_nxt;
      r_rem       <= w_rem_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
`ifdef DIVIDER_DBZ_FLAG_EN
      r_dbz       <= w_dbz_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WIDTH=4) with an expected-result scoreboard.
// Also builds with DIVIDER_DBZ_FLAG_EN defined.
module tb_sequential_divider;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic           div_by_zero;
`endif

  sequential_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] dv);
`ifdef DIVIDER_DBZ_FLAG_EN
    return (dv == '0) ? 1 : 2*W;
`else
    return 2*W;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    e.q   = (dv == '0) ? {(2*W){1'b1}} : dd / dv;
    e.r   = (dv == '0) ? dd[W-1:0] : W'(dd % dv);
    e.dbz = (dv == '0);
    sb.push_back(e);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check("busy_on_accept", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int   n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check({tag, "_latency"}, n, lat);
    check({tag, "_sb_has_entry"}, (sb.size() > 0), 1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_busy_low"}, busy, 0);
`ifdef DIVIDER_DBZ_FLAG_EN
      check({tag, "_dbz"}, div_by_zero, e.dbz);
`endif
    end
  endtask

  task automatic div_and_check(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    issue(dd, dv);
    wait_done(tag, exp_latency(dv));
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int   ndone;
    exp_t prev;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    div_and_check("d0F_3", 8'h0F, 4'h3);
    div_and_check("d64_7", 8'h64, 4'h7);
    div_and_check("dE1_F", 8'hE1, 4'hF);
    div_and_check("dFF_1", 8'hFF, 4'h1);
    for (int i = 0; i < 6; i++) begin
      div_and_check("rand", 8'($urandom), 4'($urandom_range(1, 15)));
    end

    // Start while busy is ignored.
    issue(8'h24, 4'h3);
    @(negedge clk); @(negedge clk);
    dividend = 8'hFF; divisor = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_run", busy, 1);
    wait_done("ignored_start", 2*W - 3);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_extra_done", ndone, 0);

    // Reset mid-division aborts without a done pulse.
    issue(8'h50, 4'h5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    div_and_check("d50_5", 8'h50, 4'h5);

    // Start in the done cycle; old results held until the new one completes.
    issue(8'h64, 4'h7);
    wait_done("pre_b2b", 2*W);
    prev.q = 8'h0E; prev.r = 4'h2;
    issue(8'hC8, 4'h9);
    check("b2b_done_drop", done, 0);
    check("b2b_hold_q", quotient, prev.q);
    @(negedge clk); @(negedge clk);
    check("b2b_hold_q_later", quotient, prev.q);
    check("b2b_hold_r_later", remainder, prev.r);
    wait_done("b2b", 2*W - 2);

    // Divide by zero.
    @(negedge clk);
    issue(8'h09, 4'h0);
    wait_done("dbz", exp_latency(4'h0));
`ifdef DIVIDER_DBZ_FLAG_EN
    @(negedge clk);
    check("dbz_hold", div_by_zero, 1);
`endif
    @(negedge clk);
    div_and_check("after_dbz", 8'h0F, 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
